// File: rtl/calc1_pkg.sv
// Shared calc1 protocol constants: command codes, response codes and responder FSM encoding.
package calc1_pkg;
    typedef logic [0:3]  cmd_t;
    typedef logic [0:1]  rsp_t;
    typedef logic [0:31] word_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_LSH = 4'd5;
    localparam cmd_t CMD_RSH = 4'd6;

    localparam rsp_t RSP_NONE = 2'd0;
    localparam rsp_t RSP_SUCC = 2'd1;
    localparam rsp_t RSP_INOF = 2'd2;
    localparam rsp_t RSP_IERR = 2'd3;

    // Three bits so that corrupted encodings exist and can be caught.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OPND2 = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
endpackage

// File: rtl/calc1_port_responder_if.sv
// One calc1 requester port: command/operand in, response/status out.
interface calc1_port_responder_if;
    import calc1_pkg::*;
    cmd_t  req_cmd_in;
    word_t req_data_in;
    rsp_t  out_resp;
    word_t out_data;
    logic  busy;
    logic  proto_err;

    modport master (output req_cmd_in, req_data_in,
                    input  out_resp, out_data, busy, proto_err);
    modport slave  (input  req_cmd_in, req_data_in,
                    output out_resp, out_data, busy, proto_err);
endinterface

// File: rtl/calc1_alu.sv
// Combinational calc1 execute stage: unsigned add/sub/shift with overflow reporting.
module calc1_alu
    import calc1_pkg::*;
(
    input  cmd_t  cmd,
    input  word_t op1,
    input  word_t op2,
    output rsp_t  resp,
    output word_t data
);
    logic [32:0] sum;
    logic [4:0]  shamt;

    assign sum   = {1'b0, op1} + {1'b0, op2};
    assign shamt = op2[27:31];

    always_comb begin
        resp = RSP_INOF;
        data = '0;
        case (cmd)
            CMD_NOP: resp = RSP_NONE;
            CMD_ADD: if (!sum[32]) begin
                resp = RSP_SUCC;
                data = sum[31:0];
            end
            CMD_SUB: if (op2 <= op1) begin
                resp = RSP_SUCC;
                data = op1 - op2;
            end
            CMD_LSH: begin
                resp = RSP_SUCC;
                data = op1 << shamt;
            end
            CMD_RSH: begin
                resp = RSP_SUCC;
                data = op1 >> shamt;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: capture cmd/op1, then op2, wait LATENCY cycles, respond once.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input logic                     c_clk,
    input logic                     reset,
    calc1_port_responder_if.slave   bus
);
    logic [2:0] state;
    logic [3:0] cnt;
    cmd_t       cmd_q;
    word_t      op1_q;
    word_t      op2_q;
    rsp_t       resp_q;
    word_t      data_q;
    logic       busy_q;
    logic       perr_q;
    rsp_t       alu_resp;
    word_t      alu_data;
    logic       cmd_valid;

    assign cmd_valid = (bus.req_cmd_in != CMD_NOP);

    calc1_alu u_alu (
        .cmd  (cmd_q),
        .op1  (op1_q),
        .op2  (op2_q),
        .resp (alu_resp),
        .data (alu_data)
    );

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cmd_q  <= CMD_NOP;
            op1_q  <= '0;
            op2_q  <= '0;
            resp_q <= RSP_NONE;
            data_q <= '0;
            busy_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses unless EXEC loads them.
            resp_q <= RSP_NONE;
            data_q <= '0;
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    cmd_q  <= bus.req_cmd_in;
                    op1_q  <= bus.req_data_in;
                    busy_q <= 1'b1;
                    state  <= ST_OPND2;
                end
                ST_OPND2: begin
                    op2_q <= bus.req_data_in;
                    cnt   <= 4'(LATENCY - 1);
                    state <= ST_EXEC;
                    if (cmd_valid) perr_q <= 1'b1;
                end
                ST_EXEC: begin
                    if (cmd_valid) perr_q <= 1'b1;
                    if (cnt == '0) begin
                        resp_q <= alu_resp;
                        data_q <= alu_data;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (cmd_valid) perr_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    resp_q <= RSP_IERR;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_resp  = resp_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_calc1_port_responder.sv
// Self-checking bench for calc1_port_responder: directed vector table, random vs. model, corner sequences.
module tb_calc1_port_responder;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    calc1_port_responder_if bus ();

    calc1_port_responder #(.LATENCY(LAT)) dut (
        .c_clk (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operand values.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
        longint unsigned s;
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s < 64'h1_0000_0000) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    // Caller is at a negedge with the DUT idle; leaves at the negedge after RESP ends.
    task automatic txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [1:0] er, input logic [31:0] ed, input string nm);
        bus.req_cmd_in  = cmd;
        bus.req_data_in = op1;
        @(negedge clk);
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = op2;
        repeat (LAT) @(negedge clk);
        bus.req_data_in = $urandom;
        chk({nm, ".early"}, 32'(bus.out_resp), 32'd0);
        @(negedge clk);
        chk({nm, ".resp"}, 32'(bus.out_resp), 32'(er));
        chk({nm, ".data"}, bus.out_data, ed);
        chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk({nm, ".clr"}, {bus.out_data[0:29], bus.out_resp}, 32'd0);
        chk({nm, ".idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [1:0]  er;
        logic [31:0] ed;
        logic [31:0] a, b;
        logic [3:0]  c;
        logic [3:0]  pick[8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd4, 4'd13};
        logic        seen;

        vecs[0] = '{"add",      4'd1, 32'd255,       32'd1,         2'd1, 32'd256};
        vecs[1] = '{"add_ovf",  4'd1, 32'hFFFF_FFFF, 32'd1,         2'd2, 32'd0};
        vecs[2] = '{"add_max",  4'd1, 32'hFFFF_FFFE, 32'd1,         2'd1, 32'hFFFF_FFFF};
        vecs[3] = '{"sub_unf",  4'd2, 32'd3,         32'd5,         2'd2, 32'd0};
        vecs[4] = '{"sub_eq",   4'd2, 32'd7,         32'd7,         2'd1, 32'd0};
        vecs[5] = '{"sub",      4'd2, 32'd10,        32'd3,         2'd1, 32'd7};
        vecs[6] = '{"lsh",      4'd5, 32'd1,         32'h0000_0021, 2'd1, 32'd2};
        vecs[7] = '{"rsh",      4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'd1};
        vecs[8] = '{"inv4",     4'd4, 32'd12,        32'd34,        2'd2, 32'd0};
        vecs[9] = '{"inv15",    4'd15, 32'hFFFF_FFFF, 32'd1,        2'd2, 32'd0};

        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = 32'd0;
        @(negedge clk);
        chk("rst.resp", 32'(bus.out_resp), 32'd0);
        chk("rst.data", bus.out_data, 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.perr", 32'(bus.proto_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            txn(vecs[i].cmd, vecs[i].op1, vecs[i].op2, vecs[i].resp, vecs[i].data, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            c = pick[$urandom_range(0, 7)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | a;
            model(c, a, b, er, ed);
            txn(c, a, b, er, ed, $sformatf("rnd%0d", i));
        end
        chk("rnd.perr", 32'(bus.proto_err), 32'd0);

        // Command during EXEC is dropped; flag sets; in-flight result intact.
        bus.req_cmd_in = 4'd1; bus.req_data_in = 32'd100;
        @(negedge clk);
        bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd23;
        @(negedge clk);
        bus.req_cmd_in = 4'd1; bus.req_data_in = 32'd777;
        @(negedge clk);
        bus.req_cmd_in = 4'd0;
        chk("exec_cmd.perr", 32'(bus.proto_err), 32'd1);
        repeat (LAT - 1) @(negedge clk);
        chk("exec_cmd.resp", 32'(bus.out_resp), 32'd1);
        chk("exec_cmd.data", bus.out_data, 32'd123);
        @(negedge clk);
        chk("exec_cmd.clr", 32'(bus.out_resp), 32'd0);
        txn(4'd1, 32'd1, 32'd2, 2'd1, 32'd3, "after_resp");
        chk("perr.sticky", 32'(bus.proto_err), 32'd1);

        // Command in the RESP cycle is dropped too.
        do_reset();
        chk("rst2.perr", 32'(bus.proto_err), 32'd0);
        bus.req_cmd_in = 4'd1; bus.req_data_in = 32'd5;
        @(negedge clk);
        bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd6;
        repeat (LAT + 1) @(negedge clk);
        chk("resp_cmd.resp", 32'(bus.out_resp), 32'd1);
        chk("resp_cmd.data", bus.out_data, 32'd11);
        bus.req_cmd_in = 4'd2; bus.req_data_in = 32'd9;
        @(negedge clk);
        bus.req_cmd_in = 4'd0;
        chk("resp_cmd.perr", 32'(bus.proto_err), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            if (bus.out_resp != 2'd0 || bus.busy) seen = 1'b1;
            @(negedge clk);
        end
        chk("resp_cmd.quiet", 32'(seen), 32'd0);

        // Reset mid-EXEC discards the transaction.
        bus.req_cmd_in = 4'd2; bus.req_data_in = 32'd50;
        @(negedge clk);
        bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd8;
        @(negedge clk);
        chk("pre_rst.busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.busy", 32'(bus.busy), 32'd0);
        chk("async_rst.perr", 32'(bus.proto_err), 32'd0);
        chk("async_rst.resp", 32'(bus.out_resp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (bus.out_resp != 2'd0 || bus.busy) seen = 1'b1;
        end
        chk("post_rst.quiet", 32'(seen), 32'd0);
        txn(4'd2, 32'd50, 32'd8, 2'd1, 32'd42, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
